mem_bus_arbiter: RTL

//  Shares the single main-memory port between two cache controllers (req 0 = I-cache, req 1 = D-cache).
//  - Arbitrates line requests round-robin and sequences a LINE_WORDS-beat line transfer.
//  - Times each beat with an internal MEM_LAT countdown, replacing per-controller wait counters.
//  - Returns read words and a completion pulse to the granted controller.

---
 rtl/mem_bus_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between I-cache (req 0) and D-cache (req 1), sequencing line transfers.
// Define MEM_ARB_FIXED_PRI_EN for fixed priority (requester 1 wins); default is round-robin.
module mem_bus_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LINE_WORDS = 4,
  parameter int MEM_LAT = 4,
  localparam int LB = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        rw,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [LB-1:0]     beat,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        done,
  output logic              mem_strobe,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, XFER, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] gnt_q, gnt_d, win;
  logic [LB-1:0] beat_q, beat_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rw_q, rw_d, last_q, last_d, rvalid_q, rvalid_d, act;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
`ifdef MEM_ARB_FIXED_PRI_EN
  assign win = req[1] ? 2'b10 : 2'b01;
`else
  // last_q names the requester served most recently; on a tie the other one wins
  assign win = (req == 2'b11) ? (last_q ? 2'b01 : 2'b10) : (req[1] ? 2'b10 : 2'b01);
`endif
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    beat_d = beat_q;
    cnt_d = cnt_q;
    rw_d = rw_q;
    base_d = base_q;
    last_d = last_q;
    rdata_d = rdata_q;
    rvalid_d = 1'b0;
    case (state_q)
      IDLE: if (|req) begin
        gnt_d = win;
        rw_d = win[1] ? rw[1] : rw[0];
        base_d = win[1] ? addr1 : addr0;
        beat_d = '0;
        state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d = CW'(MEM_LAT - 1);
        state_d = WAIT;
      end
      WAIT: if (cnt_q == '0) state_d = XFER;
            else cnt_d = cnt_q - 1'b1;
      XFER: begin
        rdata_d = rw_q ? mem_rdata : rdata_q;
        rvalid_d = rw_q;
        state_d = (beat_q == LB'(LINE_WORDS - 1)) ? DONE : ISSUE;
        beat_d = (beat_q == LB'(LINE_WORDS - 1)) ? beat_q : beat_q + 1'b1;
      end
      DONE: begin
        gnt_d = '0;
        beat_d = '0;
        last_d = gnt_q[1];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q <= '0;
      beat_q <= '0;
      cnt_q <= '0;
      rw_q <= 1'b0;
      base_q <= '0;
      last_q <= 1'b1;
      rdata_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      beat_q <= beat_d;
      cnt_q <= cnt_d;
      rw_q <= rw_d;
      base_q <= base_d;
      last_q <= last_d;
      rdata_q <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end
  assign act = (state_q == ISSUE) || (state_q == WAIT) || (state_q == XFER);
  assign gnt = gnt_q;
  assign beat = beat_q;
  assign rvalid = rvalid_q;
  assign rdata = rdata_q;
  assign done = (state_q == DONE) ? gnt_q : 2'b00;
  assign mem_strobe = state_q == ISSUE;
  assign mem_rw = act & rw_q;
  assign mem_addr = act ? ((base_q & ~ADDR_W'(LINE_WORDS - 1)) | ADDR_W'(beat_q)) : '0;
  assign mem_wdata = gnt_q[1] ? wdata1 : wdata0;
endmodule
